// File: rtl/quant_drain_ctrl.sv
// Drains the psum buffer row by row, quantizes each row into NUM_COL signed lanes
// (round half away from zero, then saturate) and writes packed words to out_buffer.

module quant_drain_ctrl #(
    parameter int NUM_COL   = 4,
    parameter int NUM_ROW   = 4,
    parameter int INPUT_DW  = 24,
    parameter int INPUT_IT  = 17,
    parameter int INPUT_PC  = 6,
    parameter int OUTPUT_DW = 8,
    parameter int OUTPUT_IT = 4,
    parameter int OUTPUT_PC = 3,
    parameter int ADDR_W    = 8,
    parameter int SAT_CW    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    output logic                          busy,
    output logic                          done,
    output logic                          rd_en,
    output logic [$clog2(NUM_ROW)-1:0]    rd_row,
    input  logic [NUM_COL*INPUT_DW-1:0]   psum_rdata,
    output logic                          wr_en,
    input  logic                          wr_ready,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [NUM_COL*OUTPUT_DW-1:0]  wr_data,
    input  logic                          clr_sat,
    output logic [SAT_CW-1:0]             sat_cnt
);

    localparam int ROW_W   = $clog2(NUM_ROW);
    localparam int DROP_W  = INPUT_PC - OUTPUT_PC;
    localparam int TRUNC_W = INPUT_DW - DROP_W;
    // One guard bit above the truncated value so the rounding increment never wraps.
    localparam int SUM_W   = TRUNC_W + 1;
    localparam int CHK_W   = SUM_W - OUTPUT_DW + 1;
    localparam int NSAT_W  = $clog2(NUM_COL + 1);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROW - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_QNT  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                    state_r;
    logic [ROW_W-1:0]          row_r;
    logic [ADDR_W-1:0]         base_r;
    logic [NUM_COL*OUTPUT_DW-1:0] q_data_s;
    logic [NSAT_W-1:0]         nsat_s;
    logic [OUTPUT_DW:0]        lane_q_s;
    logic [SAT_CW:0]           sat_sum_s;
    logic [SAT_CW-1:0]         sat_next_s;

    // Returns {saturated, quantized lane}.
    function automatic logic [OUTPUT_DW:0] quant_lane(input logic [INPUT_DW-1:0] psum);
        logic [TRUNC_W-1:0]   trunc_v;
        logic                 rnd_v;
        logic [SUM_W-1:0]     sum_v;
        logic [CHK_W-1:0]     top_v;
        logic                 sat_v;
        logic [OUTPUT_DW-1:0] q_v;
        trunc_v = psum[INPUT_DW-1:DROP_W];
        // Negative ties must not round toward zero, so they need a nonzero tail.
        rnd_v   = psum[DROP_W-1] & (~psum[INPUT_DW-1] | (|psum[DROP_W-2:0]));
        sum_v   = {trunc_v[TRUNC_W-1], trunc_v} + {{(SUM_W-1){1'b0}}, rnd_v};
        top_v   = sum_v[SUM_W-1 -: CHK_W];
        sat_v   = (top_v != {CHK_W{1'b0}}) && (top_v != {CHK_W{1'b1}});
        if (sat_v) begin
            q_v = sum_v[SUM_W-1] ? {1'b1, {(OUTPUT_DW-1){1'b0}}}
                                 : {1'b0, {(OUTPUT_DW-1){1'b1}}};
        end else begin
            q_v = sum_v[OUTPUT_DW-1:0];
        end
        return {sat_v, q_v};
    endfunction

    // Quantize every lane of the returned row and count saturated lanes.
    always_comb begin
        q_data_s = {(NUM_COL*OUTPUT_DW){1'b0}};
        nsat_s   = {NSAT_W{1'b0}};
        lane_q_s = {(OUTPUT_DW+1){1'b0}};
        for (int i = 0; i < NUM_COL; i++) begin
            lane_q_s = quant_lane(psum_rdata[i*INPUT_DW +: INPUT_DW]);
            q_data_s[i*OUTPUT_DW +: OUTPUT_DW] = lane_q_s[OUTPUT_DW-1:0];
            nsat_s = nsat_s + {{(NSAT_W-1){1'b0}}, lane_q_s[OUTPUT_DW]};
        end
    end

    // Saturating accumulation of the per-row saturated-lane count.
    always_comb begin
        sat_sum_s = {1'b0, sat_cnt} + {{(SAT_CW+1-NSAT_W){1'b0}}, nsat_s};
        if (sat_sum_s[SAT_CW]) begin
            sat_next_s = {SAT_CW{1'b1}};
        end else begin
            sat_next_s = sat_sum_s[SAT_CW-1:0];
        end
    end

    // Drain sequencer with registered handshake and data outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            row_r   <= {ROW_W{1'b0}};
            base_r  <= {ADDR_W{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rd_row  <= {ROW_W{1'b0}};
            wr_en   <= 1'b0;
            wr_addr <= {ADDR_W{1'b0}};
            wr_data <= {(NUM_COL*OUTPUT_DW){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r <= ST_RD;
                        base_r  <= base_addr;
                        row_r   <= {ROW_W{1'b0}};
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_row  <= {ROW_W{1'b0}};
                    end
                end
                ST_RD: begin
                    rd_en   <= 1'b0;
                    state_r <= ST_QNT;
                end
                ST_QNT: begin
                    wr_en   <= 1'b1;
                    wr_data <= q_data_s;
                    wr_addr <= base_r + {{(ADDR_W-ROW_W){1'b0}}, row_r};
                    state_r <= ST_WR;
                end
                ST_WR: begin
                    if (wr_ready) begin
                        wr_en <= 1'b0;
                        if (row_r == LAST_ROW) begin
                            state_r <= ST_DONE;
                        end else begin
                            row_r   <= row_r + ROW_ONE;
                            rd_row  <= row_r + ROW_ONE;
                            rd_en   <= 1'b1;
                            state_r <= ST_RD;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    rd_en   <= 1'b0;
                    wr_en   <= 1'b0;
                end
            endcase
        end
    end

    // Saturation counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= {SAT_CW{1'b0}};
        end else if (clr_sat) begin
            sat_cnt <= {SAT_CW{1'b0}};
        end else if (state_r == ST_QNT) begin
            sat_cnt <= sat_next_s;
        end
    end

    quant_drain_ctrl_chk #(
        .ADDR_W (ADDR_W),
        .DATA_W (NUM_COL*OUTPUT_DW)
    ) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

endmodule

// Protocol checker: write hold under backpressure and mutually exclusive strobes.
module quant_drain_ctrl_chk #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              rst_n,
    input logic              busy,
    input logic              done,
    input logic              rd_en,
    input logic              wr_en,
    input logic              wr_ready,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
);

    logic              stall_r;
    logic [ADDR_W-1:0] addr_q_r;
    logic [DATA_W-1:0] data_q_r;

    // Remember a stalled write so the next cycle can be compared against it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_r  <= 1'b0;
            addr_q_r <= {ADDR_W{1'b0}};
            data_q_r <= {DATA_W{1'b0}};
        end else begin
            stall_r  <= wr_en & ~wr_ready;
            addr_q_r <= wr_addr;
            data_q_r <= wr_data;
        end
    end

    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        stall_r |-> (wr_en && (wr_addr == addr_q_r) && (wr_data == data_q_r)));
    a_excl: assert property (@(posedge clk) disable iff (!rst_n) !(rd_en && wr_en));
    a_done: assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy);

endmodule

// File: tb/tb_quant_drain_ctrl.sv
// Directed self-checking bench for quant_drain_ctrl with hand-computed rows.

module tb_quant_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [1:0]  rd_row;
    logic [95:0] psum_rdata = 96'd0;
    logic        wr_en;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clr_sat;
    logic [15:0] sat_cnt;

    always #5 clk = ~clk;

    quant_drain_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_row     (rd_row),
        .psum_rdata (psum_rdata),
        .wr_en      (wr_en),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clr_sat    (clr_sat),
        .sat_cnt    (sat_cnt)
    );

    logic signed [23:0] mem [0:3][0:3];
    logic [31:0] exp_data [0:3];
    logic [7:0]  wa [0:7];
    logic [31:0] wd [0:7];
    int          nwr;
    int          ndone;
    int          done_cyc;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_sat = 16'd0;

    // psum storage model: one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) begin
            for (int l = 0; l < 4; l++) psum_rdata[l*24 +: 24] <= mem[rd_row][l];
        end
    end

    task automatic run_drain(input logic [7:0] base, input int stall_row, input int stall_len,
                             input int pulse_at, input int clr_at);
        int cyc;
        int left;
        logic held;
        logic [7:0]  h_addr;
        logic [31:0] h_data;
        nwr = 0; ndone = 0; done_cyc = -1; left = stall_len; held = 1'b0;
        h_addr = 8'd0; h_data = 32'd0;
        @(negedge clk); start = 1'b1; base_addr = base;
        @(posedge clk);
        @(negedge clk); start = 1'b0; base_addr = 8'h5A;
        cyc = 0;
        while (cyc < 100 && done_cyc < 0) begin
            start   = (cyc == pulse_at);
            clr_sat = (cyc == clr_at);
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end else begin
                wr_ready = 1'b1;
                if (wr_en && wr_addr == base + 8'(stall_row) && left > 0) begin
                    wr_ready = 1'b0;
                    if (held) begin
                        checks++;
                        if (wr_addr !== h_addr || wr_data !== h_data || rd_en !== 1'b0) begin
                            errors++;
                            $display("FAIL stall_hold: got addr=%h data=%h rd_en=%b expected addr=%h data=%h rd_en=0",
                                     wr_addr, wr_data, rd_en, h_addr, h_data);
                        end
                    end
                    held = 1'b1; h_addr = wr_addr; h_data = wr_data; left--;
                end
                if (wr_en && wr_ready && nwr < 8) begin
                    wa[nwr] = wr_addr; wd[nwr] = wr_data; nwr++;
                end
                @(posedge clk); @(negedge clk); cyc++;
            end
        end
        start = 1'b0; clr_sat = 1'b0; wr_ready = 1'b1;
        if (done_cyc < 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got no done expected done within 100 cycles");
        end
        repeat (20) begin
            @(posedge clk); @(negedge clk);
            if (done) ndone++;
            if (wr_en) nwr++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, rd_en, rd_row, wr_en, wr_addr, wr_data, sat_cnt} !== 62'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b rd_en=%b rd_row=%h wr_en=%b wr_addr=%h wr_data=%h sat=%h expected all 0",
                     busy, done, rd_en, rd_row, wr_en, wr_addr, wr_data, sat_cnt);
        end
    endtask

    task automatic test_round();
        mem[1][0] = 24'sd8; mem[1][1] = -24'sd8; mem[1][2] = 24'sd4; mem[1][3] = -24'sd4;
        run_drain(8'h10, -1, 0, -1, -1);
        checks++;
        if (wd[0] !== 32'hFE02FD03 || wa[0] !== 8'h10) begin
            errors++;
            $display("FAIL round_ties: got addr=%h data=%h expected addr=10 data=fe02fd03", wa[0], wd[0]);
        end
        checks++;
        if (wd[1] !== 32'hFF01FF01) begin
            errors++;
            $display("FAIL round_half_small: got %h expected ff01ff01", wd[1]);
        end
        checks++;
        if (sat_cnt !== exp_sat) begin
            errors++;
            $display("FAIL round_sat_cnt: got %h expected %h", sat_cnt, exp_sat);
        end
        mem[1][0] = 24'sd1016; mem[1][1] = -24'sd1032; mem[1][2] = 24'sd1011; mem[1][3] = 24'sd1020;
    endtask

    task automatic test_saturate();
        run_drain(8'h20, -1, 0, -1, -1);
        exp_sat = exp_sat + 16'd2;
        checks++;
        if (wd[1] !== 32'h7F7E807F) begin
            errors++;
            $display("FAIL saturate_data: got %h expected 7f7e807f", wd[1]);
        end
        checks++;
        if (sat_cnt !== exp_sat) begin
            errors++;
            $display("FAIL saturate_cnt: got %h expected %h", sat_cnt, exp_sat);
        end
    endtask

    task automatic test_full_drain();
        logic [7:0] a;
        run_drain(8'hFE, -1, 0, -1, -1);
        exp_sat = exp_sat + 16'd2;
        a = 8'hFE;
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (wa[r] !== a || wd[r] !== exp_data[r]) begin
                errors++;
                $display("FAIL full_row%0d: got addr=%h data=%h expected addr=%h data=%h",
                         r, wa[r], wd[r], a, exp_data[r]);
            end
            a = a + 8'd1;
        end
        checks++;
        if (done_cyc !== 13 || ndone !== 1 || nwr !== 4) begin
            errors++;
            $display("FAIL full_timing: got done_cyc=%0d dones=%0d writes=%0d expected 13 1 4",
                     done_cyc, ndone, nwr);
        end
    endtask

    task automatic test_backpressure();
        run_drain(8'h40, 1, 5, -1, -1);
        exp_sat = exp_sat + 16'd2;
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (wa[r] !== 8'h40 + 8'(r) || wd[r] !== exp_data[r]) begin
                errors++;
                $display("FAIL bp_row%0d: got addr=%h data=%h expected addr=%h data=%h",
                         r, wa[r], wd[r], 8'h40 + 8'(r), exp_data[r]);
            end
        end
        checks++;
        if (done_cyc !== 18 || ndone !== 1 || nwr !== 4) begin
            errors++;
            $display("FAIL bp_timing: got done_cyc=%0d dones=%0d writes=%0d expected 18 1 4",
                     done_cyc, ndone, nwr);
        end
    endtask

    task automatic test_busy_start();
        run_drain(8'h50, -1, 0, 5, -1);
        exp_sat = exp_sat + 16'd2;
        checks++;
        if (done_cyc !== 13 || ndone !== 1 || nwr !== 4) begin
            errors++;
            $display("FAIL busy_start_mid: got done_cyc=%0d dones=%0d writes=%0d expected 13 1 4",
                     done_cyc, ndone, nwr);
        end
        run_drain(8'h60, -1, 0, 12, -1);
        exp_sat = exp_sat + 16'd2;
        checks++;
        if (done_cyc !== 13 || ndone !== 1 || nwr !== 4) begin
            errors++;
            $display("FAIL busy_start_done: got done_cyc=%0d dones=%0d writes=%0d expected 13 1 4",
                     done_cyc, ndone, nwr);
        end
    endtask

    task automatic test_clr_sat();
        checks++;
        if (sat_cnt !== exp_sat) begin
            errors++;
            $display("FAIL clr_pre_cnt: got %h expected %h", sat_cnt, exp_sat);
        end
        run_drain(8'h70, -1, 0, -1, 4);
        exp_sat = 16'd0;
        checks++;
        if (sat_cnt !== exp_sat) begin
            errors++;
            $display("FAIL clr_priority: got %h expected %h", sat_cnt, exp_sat);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); start = 1'b1; base_addr = 8'h30;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 8'h32) begin
            errors++;
            $display("FAIL mid_in_wr2: got wr_en=%b addr=%h expected 1 32", wr_en, wr_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, rd_en, rd_row, wr_en, wr_addr, wr_data, sat_cnt} !== 62'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b rd_en=%b wr_en=%b wr_addr=%h wr_data=%h sat=%h expected all 0",
                     busy, done, rd_en, wr_en, wr_addr, wr_data, sat_cnt);
        end
        @(negedge clk); rst_n = 1'b1;
        exp_sat = 16'd0;
        ndone = 0;
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL mid_no_done: got %0d active cycles expected 0", ndone);
        end
        run_drain(8'h30, -1, 0, -1, -1);
        exp_sat = exp_sat + 16'd2;
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (wa[r] !== 8'h30 + 8'(r) || wd[r] !== exp_data[r]) begin
                errors++;
                $display("FAIL mid_row%0d: got addr=%h data=%h expected addr=%h data=%h",
                         r, wa[r], wd[r], 8'h30 + 8'(r), exp_data[r]);
            end
        end
        checks++;
        if (done_cyc !== 13 || ndone !== 1 || sat_cnt !== exp_sat) begin
            errors++;
            $display("FAIL mid_redrain: got done_cyc=%0d dones=%0d sat=%h expected 13 1 %h",
                     done_cyc, ndone, sat_cnt, exp_sat);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = 8'h00; wr_ready = 1'b1; clr_sat = 1'b0;
        mem[0][0] = 24'sd20;   mem[0][1] = -24'sd20;   mem[0][2] = 24'sd19;   mem[0][3] = -24'sd19;
        mem[1][0] = 24'sd1016; mem[1][1] = -24'sd1032; mem[1][2] = 24'sd1011; mem[1][3] = 24'sd1020;
        mem[2][0] = 24'sd8;    mem[2][1] = -24'sd8;    mem[2][2] = 24'sd4;    mem[2][3] = -24'sd4;
        mem[3][0] = 24'sd0;    mem[3][1] = 24'sd3;     mem[3][2] = -24'sd5;   mem[3][3] = 24'sd5;
        exp_data[0] = 32'hFE02FD03;
        exp_data[1] = 32'h7F7E807F;
        exp_data[2] = 32'hFF01FF01;
        exp_data[3] = 32'h01FF0000;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_round();
        test_saturate();
        test_full_drain();
        test_backpressure();
        test_busy_start();
        test_clr_sat();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
